mem_port_arbiter: RTL and testbench

- Shares one main-memory port between NUM_REQ processing blocks.
- Each processing block presents load/write requests using the same signals it already drives: load_ctrl/load_addr and write_ctrl/write_addr/write_data, with 512-bit data = 32 bf16 lanes.
- Arbitration is round-robin, one memory access per cycle.
- Read data is returned to the issuing requester after a fixed memory latency, marked by a per-requester valid pulse.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between NUM_REQ processing blocks.
// Define MEM_PORT_ARB_PERF_EN to add the saturating conflict_count output.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 512,
    parameter int MEM_LAT = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_load_ctrl,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_load_addr,
    input  logic [NUM_REQ-1:0]          req_write_ctrl,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_write_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_write_data,
    output logic [NUM_REQ-1:0]          req_grant,
    output logic [NUM_REQ-1:0]          req_load_valid,
    output logic [DATA_W-1:0]           load_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rd_en,
    output logic                        mem_wr_en,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic [DATA_W-1:0]           mem_rd_data
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [31:0]                 conflict_count
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][ADDR_W-1:0] ld_addr, wr_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]             elig;
    logic [PW-1:0]                  ptr, sel, ptr_nxt;
    logic [PW:0]                    cand;
    logic                           found, sel_wr;
    logic [MEM_LAT-1:0]             vld_pipe;
    logic [MEM_LAT-1:0][PW-1:0]     tag_pipe;

    assign ld_addr = req_load_addr;
    assign wr_addr = req_write_addr;
    assign wr_data = req_write_data;

    // The requester granted this cycle still holds its old request; keep it out of the race.
    assign elig = (req_load_ctrl | req_write_ctrl) & ~req_grant;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ))
                cand = cand - (PW+1)'(NUM_REQ);
            if (!found && elig[cand[PW-1:0]]) begin
                found = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
        // A write wins over a simultaneous load; the load re-competes later.
        sel_wr  = req_write_ctrl[sel];
        ptr_nxt = (sel == PW'(NUM_REQ-1)) ? '0 : sel + PW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_grant      <= '0;
            req_load_valid <= '0;
            load_data      <= '0;
            mem_addr       <= '0;
            mem_rd_en      <= 1'b0;
            mem_wr_en      <= 1'b0;
            mem_wr_data    <= '0;
            ptr            <= '0;
            vld_pipe       <= '0;
            tag_pipe       <= '0;
        end else begin
            if (found) begin
                req_grant   <= NUM_REQ'(1) << sel;
                ptr         <= ptr_nxt;
                mem_addr    <= sel_wr ? wr_addr[sel] : ld_addr[sel];
                mem_wr_en   <= sel_wr;
                mem_rd_en   <= ~sel_wr;
                mem_wr_data <= sel_wr ? wr_data[sel] : '0;
            end else begin
                req_grant   <= '0;
                mem_addr    <= '0;
                mem_wr_en   <= 1'b0;
                mem_rd_en   <= 1'b0;
                mem_wr_data <= '0;
            end
            vld_pipe[0] <= found & ~sel_wr;
            tag_pipe[0] <= sel;
            for (int k = 1; k < MEM_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
            req_load_valid <= vld_pipe[MEM_LAT-1] ? (NUM_REQ'(1) << tag_pipe[MEM_LAT-1]) : '0;
            if (vld_pipe[MEM_LAT-1])
                load_data <= mem_rd_data;
        end
    end

`ifdef MEM_PORT_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset)
            conflict_count <= '0;
        else if ($countones(elig) >= 2 && conflict_count != 32'hFFFF_FFFF)
            conflict_count <= conflict_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random and directed requests, a reference
// round-robin model, and a fixed-latency memory whose data is a function of address.
module tb_mem_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 512;
    localparam int MEM_LAT = 2;
    localparam int DI      = (MEM_LAT >= 2) ? MEM_LAT - 2 : 0;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } op_t;

    typedef struct {
        int                due;
        int                req;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [NUM_REQ-1:0]             ld_ctrl, wr_ctrl;
    logic [NUM_REQ-1:0][ADDR_W-1:0] ld_addr, wr_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]             req_grant, req_load_valid;
    logic [DATA_W-1:0]              load_data, mem_wr_data, mem_rd_data;
    logic [ADDR_W-1:0]              mem_addr;
    logic                           mem_rd_en, mem_wr_en;
    logic [ADDR_W-1:0]              adreg [MEM_LAT];
`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0]                    conflict_count;
`endif

    mem_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clock(clock), .reset(reset),
        .req_load_ctrl(ld_ctrl), .req_load_addr(ld_addr),
        .req_write_ctrl(wr_ctrl), .req_write_addr(wr_addr), .req_write_data(wr_data),
        .req_grant(req_grant), .req_load_valid(req_load_valid), .load_data(load_data),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef MEM_PORT_ARB_PERF_EN
        , .conflict_count(conflict_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return {(DATA_W/16){a ^ 16'h3e4d}};
    endfunction

    // Memory: data for the address issued with mem_rd_en is presented MEM_LAT edges later.
    always @(posedge clock) begin
        adreg[0] <= mem_addr;
        for (int k = 1; k < MEM_LAT; k++) adreg[k] <= adreg[k-1];
    end
    assign mem_rd_data = data_of(MEM_LAT == 1 ? mem_addr : adreg[DI]);

    op_t  exp_q [NUM_REQ][$];
    ret_t ret_q [$];
    int   checks = 0, errors = 0, cyc = 0, mptr = 0, perf_exp = 0;
    int   waitc [NUM_REQ];
    logic [NUM_REQ-1:0] exp_grant = '0;
    bit   just_reset = 1'b0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        op_t op;
        ret_t r;
        int s;
        logic [NUM_REQ-1:0] el;
        cyc++;
        if (reset) begin
            mptr = 0;
            exp_grant = '0;
            ret_q.delete();
            for (int i = 0; i < NUM_REQ; i++) waitc[i] = 0;
            perf_exp = 0;
            just_reset = 1'b1;
        end else begin
            if (just_reset) begin
                chk("rst_rd_en", DATA_W'(mem_rd_en), '0);
                chk("rst_wr_en", DATA_W'(mem_wr_en), '0);
                chk("rst_addr", DATA_W'(mem_addr), '0);
                chk("rst_load_data", load_data, '0);
                just_reset = 1'b0;
            end
            chk("grant", DATA_W'(req_grant), DATA_W'(exp_grant));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_grant[i]) begin
                    checks++;
                    if (waitc[i] > NUM_REQ) begin
                        errors++;
                        $display("FAIL starve cycle %0d: req %0d waited %0d limit %0d", cyc, i, waitc[i], NUM_REQ);
                    end
                    waitc[i] = 0;
                    if (exp_q[i].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_grant cycle %0d: req %0d had nothing pending", cyc, i);
                    end else begin
                        op = exp_q[i].pop_front();
                        chk("wr_en", DATA_W'(mem_wr_en), DATA_W'(op.wr));
                        chk("rd_en", DATA_W'(mem_rd_en), DATA_W'(!op.wr));
                        chk("mem_addr", DATA_W'(mem_addr), DATA_W'(op.addr));
                        if (op.wr) chk("wr_data", mem_wr_data, op.data);
                        else ret_q.push_back('{cyc + MEM_LAT, i, data_of(op.addr)});
                    end
                end else if (ld_ctrl[i] | wr_ctrl[i]) begin
                    waitc[i]++;
                end
            end
            if (ret_q.size() != 0 && ret_q[0].due == cyc) begin
                r = ret_q.pop_front();
                chk("load_valid", DATA_W'(req_load_valid), DATA_W'(1 << r.req));
                chk("load_data", load_data, r.data);
            end else begin
                chk("load_valid_idle", DATA_W'(req_load_valid), '0);
            end
            // Reference RR: first eligible at/after pointer, excluding this cycle's grantee.
            el = (ld_ctrl | wr_ctrl) & ~exp_grant;
            if ($countones(el) >= 2) perf_exp++;
            s = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (s < 0 && el[(mptr + k) % NUM_REQ]) s = (mptr + k) % NUM_REQ;
            exp_grant = '0;
            if (s >= 0) begin
                exp_grant[s] = 1'b1;
                mptr = (s + 1) % NUM_REQ;
            end
        end
    end

    // Advance one cycle; a requester that saw its grant drops (or reduces) its request.
    task automatic step();
        logic [NUM_REQ-1:0] g;
        g = req_grant;
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (g[i]) begin
                if (wr_ctrl[i]) wr_ctrl[i] = 1'b0;
                else ld_ctrl[i] = 1'b0;
            end
    endtask

    task automatic issue(input int i, input bit ld, input bit wr, input logic [ADDR_W-1:0] la,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        if (wr) begin
            wr_ctrl[i] = 1'b1; wr_addr[i] = wa; wr_data[i] = wd;
            exp_q[i].push_back('{1'b1, wa, wd});
        end
        if (ld) begin
            ld_ctrl[i] = 1'b1; ld_addr[i] = la;
            exp_q[i].push_back('{1'b0, la, '0});
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic drain();
        for (int t = 0; t < 200 && |(ld_ctrl | wr_ctrl); t++) step();
        repeat (MEM_LAT + 3) step();
        chk("drain_idle", DATA_W'(ld_ctrl | wr_ctrl), '0);
        chk("drain_returns", DATA_W'(ret_q.size()), '0);
    endtask

    initial begin
        int kind;
        ld_ctrl = '0; wr_ctrl = '0; ld_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        issue(0, 1, 0, 16'd0, 16'd0, '0);
        repeat (6) step();

        for (int i = 0; i < NUM_REQ; i++) issue(i, 1, 0, ADDR_W'(i), 16'd0, '0);
        repeat (10) step();

        issue(2, 1, 1, 16'd5, 16'd3, {32{16'h3f1a}});
        repeat (8) step();

        repeat (24) begin
            if (!(ld_ctrl[0] | wr_ctrl[0])) issue(0, 1, 0, ADDR_W'($urandom), 16'd0, '0);
            if (!(ld_ctrl[3] | wr_ctrl[3])) issue(3, 0, 1, 16'd0, ADDR_W'($urandom), rand_data());
            step();
        end
        drain();

        repeat (1500) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!(ld_ctrl[i] | wr_ctrl[i]) && $urandom_range(0, 99) < 40) begin
                    kind = $urandom_range(0, 2);
                    issue(i, kind != 1, kind != 0, ADDR_W'($urandom), ADDR_W'($urandom), rand_data());
                end
            step();
        end
        drain();

        // Reset lands one cycle after a read grant; its return must never appear.
        issue(1, 1, 0, 16'h7, 16'd0, '0);
        for (int t = 0; t < 20 && ld_ctrl[1]; t++) step();
        chk("reset_test_grant_seen", DATA_W'(ld_ctrl[1]), '0);
        reset = 1'b1;
        ld_ctrl = '0; wr_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
        step();
        reset = 1'b0;
        repeat (MEM_LAT + 4) step();
        issue(3, 1, 0, 16'h9, 16'd0, '0);
        drain();

`ifdef MEM_PORT_ARB_PERF_EN
        chk("conflict_count", DATA_W'(conflict_count), DATA_W'(perf_exp));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
